instr_fetch_queue: RTL and testbench

- Fetch stage upstream of the decode/register-bank/ALU path. Sits between the shared word-addressed RAM port and the consumer of the current instruction.
- Owns the fetch PC and issues sequential instruction reads whenever the memory port is granted.
- Buffers returned words, tagged with their PC, in a small FIFO and presents them to decode with a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes all buffered and in-flight fetches.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/instr_fetch_queue_if.sv | 38 +++
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/instr_fetch_queue.sv | 100 ++++++++++
 tb/tb_instr_fetch_queue.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, reset address and the buffered fetch entry type for the
// instruction fetch queue.
package fetch_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 32;

   localparam logic [ADDR_W-1:0] RESET_PC_DEF = 16'h0000;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } fetch_entry_t;

   // Word-address increment; wraps modulo 2^ADDR_W
   function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
      return pc + ADDR_W'(1);
   endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Memory fetch port and decode-side valid/ready handshake of the fetch queue.
// master = fetch queue, slave = RAM controller / decode environment.
interface instr_fetch_queue_if;
   import fetch_pkg::*;

   logic              mem_grant;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;

   logic              instr_valid;
   logic [DATA_W-1:0] instr_out;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_ready;

   modport master (
      input  mem_grant,
      input  mem_rdata,
      input  instr_ready,
      output mem_rd_en,
      output mem_addr,
      output instr_valid,
      output instr_out,
      output instr_pc
   );

   modport slave (
      output mem_grant,
      output mem_rdata,
      output instr_ready,
      input  mem_rd_en,
      input  mem_addr,
      input  instr_valid,
      input  instr_out,
      input  instr_pc
   );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of fetch entries with flush; the head entry is
// visible combinationally.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             i_reset,
   input  logic             i_flush,
   input  logic             i_push,
   input  fetch_entry_t     i_push_data,
   input  logic             i_pop,
   output fetch_entry_t     o_head,
   output logic [CNT_W-1:0] o_count,
   output logic             o_empty,
   output logic             o_full
);

   fetch_entry_t     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_pop;
   logic w_push;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

   assign w_pop  = i_pop & ~o_empty & ~i_reset & ~i_flush;
   assign w_push = i_push & (~o_full | w_pop) & ~i_reset & ~i_flush;

   // Entry storage needs no reset; validity is tracked by the count
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (i_reset || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues sequential reads when
// granted, buffers PC-tagged words for decode. FETCH_PERF_EN adds a stall counter.
module instr_fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic                clk,
   input  logic                reset,
   instr_fetch_queue_if.master bus,
   input  logic                redirect_valid,
   input  logic [ADDR_W-1:0]   redirect_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]         fetch_stall_cnt
`endif
);

   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
   localparam int unsigned CRED_W = CNT_W + 1;

   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_pc_q;
   logic              r_inflight;

   logic              w_credit_ok;
   logic              w_issue;
   logic              w_push;
   logic              w_pop;
   logic              w_empty;
   logic              w_full;
   logic [CNT_W-1:0]  w_count;
   fetch_entry_t      w_head;
   fetch_entry_t      w_push_data;

   // A slot must stay reserved for the word already in flight
   assign w_credit_ok = (CRED_W'(w_count) + CRED_W'(r_inflight)) < CRED_W'(DEPTH);
   assign w_issue     = bus.mem_grant & ~redirect_valid & ~reset & w_credit_ok;

   assign bus.mem_rd_en = w_issue;
   assign bus.mem_addr  = r_pc;

   // A response landing in a redirect or reset cycle is dropped
   assign w_push      = r_inflight & ~redirect_valid & ~reset;
   assign w_push_data = '{pc: r_pc_q, instr: bus.mem_rdata};
   assign w_pop       = ~w_empty & bus.instr_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc       <= RESET_PC;
         r_pc_q     <= RESET_PC;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (redirect_valid) begin
            r_pc <= redirect_pc;
         end else if (w_issue) begin
            r_pc   <= pc_inc(r_pc);
            r_pc_q <= r_pc;
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .i_reset     (reset),
      .i_flush     (redirect_valid),
      .i_push      (w_push),
      .i_push_data (w_push_data),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_count     (w_count),
      .o_empty     (w_empty),
      .o_full      (w_full)
   );

   // Head is forced to zero while the queue is empty
   assign bus.instr_valid = ~w_empty;
   assign bus.instr_out   = w_empty ? '0 : w_head.instr;
   assign bus.instr_pc    = w_empty ? '0 : w_head.pc;

`ifdef FETCH_PERF_EN
   logic [15:0] r_stall_cnt;

   // Saturating count of cycles with nothing to hand to decode
   always_ff @(posedge clk) begin
      if (reset || redirect_valid) begin
         r_stall_cnt <= '0;
      end else if (w_empty && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign fetch_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized + directed bench for instr_fetch_queue against a queue-based model
// of owed fetch words (PC plus the cycle each becomes visible).
module tb_instr_fetch_queue;
   import fetch_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
`ifdef FETCH_PERF_EN
   logic [15:0]       fetch_stall_cnt;
`endif

   instr_fetch_queue_if bus();

   instr_fetch_queue #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC_DEF)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .bus            (bus),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_EN
      ,
      .fetch_stall_cnt(fetch_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
      return {a ^ 16'h5A3C, ~a};
   endfunction

   // RAM: fixed one-cycle read latency; junk when no read so stray pushes show
   always @(posedge clk) begin
      if (bus.mem_rd_en) bus.mem_rdata <= ram_word(bus.mem_addr);
      else               bus.mem_rdata <= 32'hDEAD_BEEF;
   end

   // Model: words owed to decode, each with the cycle it becomes visible
   typedef struct {
      logic [ADDR_W-1:0] pc;
      int                vis;
   } owed_t;

   owed_t             q[$];
   logic [ADDR_W-1:0] m_pc = RESET_PC_DEF;
   int                m_stall = 0;
   int                cyc = 0;

   logic              s_rd_en, s_valid;
   logic [ADDR_W-1:0] s_addr, s_pc;
   logic [15:0]       s_stall;

   always @(negedge clk) begin
      logic exp_valid, exp_rd;
      exp_valid = (q.size() > 0) && (q[0].vis <= cyc);
      exp_rd    = bus.mem_grant && !redirect_valid && !reset && (q.size() < int'(DEPTH));

      s_rd_en = bus.mem_rd_en;
      s_addr  = bus.mem_addr;
      s_valid = bus.instr_valid;
      s_pc    = bus.instr_pc;
`ifdef FETCH_PERF_EN
      s_stall = fetch_stall_cnt;
      chk("stall_cnt", 64'(fetch_stall_cnt), 64'(m_stall));
`else
      s_stall = 16'h0;
`endif

      chk("mem_rd_en", 64'(bus.mem_rd_en), 64'(exp_rd));
      chk("mem_addr", 64'(bus.mem_addr), 64'(m_pc));
      chk("instr_valid", 64'(bus.instr_valid), 64'(exp_valid));
      if (exp_valid) begin
         chk("instr_pc", 64'(bus.instr_pc), 64'(q[0].pc));
         chk("instr_out", 64'(bus.instr_out), 64'(ram_word(q[0].pc)));
      end else begin
         chk("empty_pc", 64'(bus.instr_pc), 64'h0);
         chk("empty_out", 64'(bus.instr_out), 64'h0);
      end

      if (reset || redirect_valid) begin
         q.delete();
         m_pc    = reset ? RESET_PC_DEF : redirect_pc;
         m_stall = 0;
      end else begin
         if (!exp_valid && m_stall < 16'hFFFF) m_stall++;
         if (exp_valid && bus.instr_ready) void'(q.pop_front());
         if (exp_rd) begin
            q.push_back('{pc: m_pc, vis: cyc + 2});
            m_pc = m_pc + 16'd1;
         end
      end
      cyc++;
   end

   // Inputs for one cycle; on return the s_* samples belong to that cycle
   task automatic step(input bit g, input bit rdy, input bit rv,
                       input logic [ADDR_W-1:0] rp, input bit rst);
      bus.mem_grant   = g;
      bus.instr_ready = rdy;
      redirect_valid  = rv;
      redirect_pc     = rp;
      reset           = rst;
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n, input bit g, input bit rdy);
      for (int i = 0; i < n; i++) step(g, rdy, 1'b0, 16'h0, 1'b0);
   endtask

   initial begin
      reset           = 1'b1;
      redirect_valid  = 1'b0;
      redirect_pc     = '0;
      bus.mem_grant   = 1'b0;
      bus.instr_ready = 1'b0;
      @(posedge clk);
      #1;
      step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);

      // Streaming: issue 0 first, data visible two cycles later
      step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
      chk("stream_first_issue", 64'(s_rd_en), 64'h1);
      chk("stream_first_addr", 64'(s_addr), 64'h0);
      run(2, 1'b1, 1'b1);
      chk("stream_first_valid", 64'(s_valid), 64'h1);
      chk("stream_first_pc", 64'(s_pc), 64'h0);
      run(10, 1'b1, 1'b1);

      // Backpressure: exactly DEPTH issues then pc parks at 4
      step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
      run(8, 1'b1, 1'b0);
      chk("bp_no_issue", 64'(s_rd_en), 64'h0);
      chk("bp_pc_hold", 64'(s_addr), 64'h4);
      run(10, 1'b1, 1'b1);

      // Redirect while words are in flight and buffered
      run(4, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1, 16'h0040, 1'b0);
      step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
      chk("redir_empty", 64'(s_valid), 64'h0);
      chk("redir_addr", 64'(s_addr), 64'h0040);
      run(8, 1'b1, 1'b1);

      // Grant steal mid-stream
      run(3, 1'b0, 1'b1);
      chk("steal_no_issue", 64'(s_rd_en), 64'h0);
      run(8, 1'b1, 1'b1);

      // Address wrap, then reset mid-stream
      step(1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b0);
      run(6, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
      chk("rst_empty", 64'(s_valid), 64'h0);
      chk("rst_addr", 64'(s_addr), 64'(RESET_PC_DEF));
      run(6, 1'b1, 1'b1);

      // Stall counter: 10 idle cycles, then cleared by redirect
      step(1'b0, 1'b1, 1'b0, 16'h0, 1'b1);
      run(10, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 16'h0100, 1'b0);
`ifdef FETCH_PERF_EN
      chk("perf_reach10", 64'(s_stall), 64'd10);
`endif
      step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
`ifdef FETCH_PERF_EN
      chk("perf_cleared", 64'(s_stall), 64'd0);
`endif

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         logic [ADDR_W-1:0] rp;
         rp = ($urandom_range(0, 1) == 0) ? 16'(16'hFFFC + 16'($urandom_range(0, 3)))
                                          : 16'($urandom());
         step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7,
              $urandom_range(0, 29) == 0, rp, $urandom_range(0, 199) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
